// File: rtl/activity_stretch_multi_if.sv
// Channel bundle for activity_stretch_multi: raw inputs, shared controls
// and the per-channel LED/status outputs.
interface activity_stretch_multi_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] din;
  logic [1:0]        mode;
  logic              retrig;
  logic [NUM_CH-1:0] dout;
  logic [NUM_CH-1:0] active;
  logic              any_active;

  modport master (
    output din, mode, retrig,
    input  dout, active, any_active
  );

  modport slave (
    input  din, mode, retrig,
    output dout, active, any_active
  );
endinterface

// File: rtl/activity_stretch_multi.sv
// activity_stretch_multi: NUM_CH asynchronous inputs are synchronised,
// edge-qualified by a shared mode, and each qualifying edge is stretched
// into a HOLD_CYCLES-long LED pulse with optional retriggering.
// Optional blink output: define ACTIVITY_STRETCH_BLINK_EN.

// One channel's hold timer (and blink phase when enabled).
module activity_stretch_lane #(
  parameter int HOLD_CYCLES = 10
`ifdef ACTIVITY_STRETCH_BLINK_EN
  , parameter int BLINK_HALF = 2
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic q,
  input  logic retrig,
  output logic act_nxt,
  output logic active,
  output logic dout
);
  localparam int            CW   = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD = CW'(HOLD_CYCLES);

  logic [CW-1:0] cnt, cnt_nxt;
  logic          load;

  // Load on an idle edge, reload on an active edge only with retrig, else count down.
  always_comb begin
    load    = 1'b0;
    cnt_nxt = cnt;
    if (cnt == '0)
      load = q;
    else if (q && retrig)
      load = 1'b1;
    if (load)
      cnt_nxt = HOLD;
    else if (cnt != '0)
      cnt_nxt = cnt - CW'(1);
  end

  assign act_nxt = (cnt_nxt != '0);

  // Timer and active flag; active is a flop so dout has no path from din.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      active <= act_nxt;
    end
  end

`ifdef ACTIVITY_STRETCH_BLINK_EN
  // Phase restarts high on every trigger/reload so each pulse starts lit.
  localparam int            BW    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] bcnt;
  logic          phase;

  // Per-channel half-period counter, only runs while the hold is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (load) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (cnt != '0) begin
      if (bcnt == BLAST) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end
  end

  assign dout = active & phase;
`else
  assign dout = active;
`endif
endmodule

module activity_stretch_multi #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int SYNC_STAGES = 2,
  parameter int BLINK_HALF  = 6250000
) (
  input logic                     clk,
  input logic                     rst,
  activity_stretch_multi_if.slave bus
);
  if (NUM_CH < 1 || NUM_CH > 32 || HOLD_CYCLES < 1 ||
      SYNC_STAGES < 2 || SYNC_STAGES > 4 || BLINK_HALF < 1) begin : g_bad_param
    $error("activity_stretch_multi: parameter out of range");
  end

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [SYNC_STAGES:0]               arm_pipe;
  logic [NUM_CH-1:0]                  s, p, rise, fall, q;
  logic [NUM_CH-1:0]                  act_nxt, act, dout;
  logic                               arm, any_q;

  assign s   = sync_q[SYNC_STAGES-1];
  assign arm = arm_pipe[SYNC_STAGES];

  // Synchroniser chain, previous-value register and arm shift register.
  // arm only rises SYNC_STAGES+1 cycles after reset so a din already high
  // at release cannot look like a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      p        <= '0;
      arm_pipe <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.din};
      p        <= s;
      arm_pipe <= {arm_pipe[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edge qualification under the shared mode, gated by arm.
  always_comb begin
    rise = s & ~p;
    fall = ~s & p;
    q    = '0;
    case (bus.mode)
      2'b00:   q = rise | fall;
      2'b01:   q = rise;
      2'b10:   q = fall;
      default: q = '0;
    endcase
    if (!arm) q = '0;
  end

  activity_stretch_lane #(
    .HOLD_CYCLES(HOLD_CYCLES)
`ifdef ACTIVITY_STRETCH_BLINK_EN
    , .BLINK_HALF(BLINK_HALF)
`endif
  ) u_lane [NUM_CH-1:0] (
    .clk    (clk),
    .rst    (rst),
    .q      (q),
    .retrig (bus.retrig),
    .act_nxt(act_nxt),
    .active (act),
    .dout   (dout)
  );

  // any_active built from next-state so it lines up with the active flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_q <= 1'b0;
    else     any_q <= |act_nxt;
  end

  assign bus.dout       = dout;
  assign bus.active     = act;
  assign bus.any_active = any_q;
endmodule

// File: tb/tb_activity_stretch_multi.sv
// Randomised + directed bench for activity_stretch_multi against an
// edge-history reference model.
module tb_activity_stretch_multi;
  localparam int NCH  = 4;
  localparam int HOLD = 10;
  localparam int SS   = 2;
  localparam int BH   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  activity_stretch_multi_if #(.NUM_CH(NCH)) bus ();

  activity_stretch_multi #(
    .NUM_CH(NCH), .HOLD_CYCLES(HOLD), .SYNC_STAGES(SS), .BLINK_HALF(BH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: din history per clock edge since reset release, and
  // the edge index of the last accepted trigger per channel.
  logic [NCH-1:0] hist[$];
  int             e;
  int             last[NCH];
  bit             act_m[NCH];
  int             act_len[NCH];

  function automatic bit hbit(int i, int ee);
    if (ee < 1) return 1'b0;
    return hist[ee-1][i];
  endfunction

  task automatic model_reset();
    e = 0;
    hist.delete();
    for (int i = 0; i < NCH; i++) begin
      last[i]  = 0;
      act_m[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [NCH-1:0] d, input logic [1:0] m, input logic rt);
    bit s, p, qual;
    e++;
    hist.push_back(d);
    for (int i = 0; i < NCH; i++) begin
      s = hbit(i, e - SS);
      p = hbit(i, e - SS - 1);
      case (m)
        2'd0:    qual = (s != p);
        2'd1:    qual = s && !p;
        2'd2:    qual = !s && p;
        default: qual = 1'b0;
      endcase
      if (e <= SS + 1) qual = 1'b0;
      if (qual && (!act_m[i] || rt)) last[i] = e;
      act_m[i] = (last[i] > 0) && ((e - last[i]) < HOLD);
    end
  endtask

  function automatic logic [NCH-1:0] exp_act();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = act_m[i];
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_dout();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) begin
`ifdef ACTIVITY_STRETCH_BLINK_EN
      r[i] = act_m[i] && ((((e - last[i]) / BH) % 2) == 0);
`else
      r[i] = act_m[i];
`endif
    end
    return r;
  endfunction

  // One clock: model follows the posedge, outputs compared on the negedge.
  task automatic step();
    @(posedge clk);
    if (!rst) model_edge(bus.din, bus.mode, bus.retrig);
    @(negedge clk);
    check("active", bus.active, exp_act());
    check("dout", bus.dout, exp_dout());
    check("any_active", bus.any_active, |exp_act());
    for (int i = 0; i < NCH; i++) if (bus.active[i]) act_len[i]++;
  endtask

  task automatic clr_len();
    for (int i = 0; i < NCH; i++) act_len[i] = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    check("rst_active", bus.active, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_any", bus.any_active, 0);
    model_reset();
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [13:0] pat;
  logic [13:0] pat_exp;

  initial begin
    bus.din    = 4'b0001;
    bus.mode   = 2'b00;
    bus.retrig = 1'b0;
    clr_len();
    #2;
    do_reset(3);

    // din held high across reset: arming must hide it.
    repeat (20) step();
    check("arm_no_false", act_len[0], 0);

    // Quietly return all inputs to 0 with edges disabled.
    bus.mode = 2'b11;
    bus.din  = '0;
    repeat (6) step();
    check("mode_off", act_len[0], 0);

    // Any-edge single pulse on ch0.
    bus.mode = 2'b00;
    clr_len();
    bus.din[0] = 1'b1;
    repeat (20) step();
    check("len_ch0", act_len[0], HOLD);
    check("len_others", act_len[1] + act_len[2] + act_len[3], 0);

    // Rising-only then falling-only on ch1.
    bus.mode = 2'b01;
    clr_len();
    bus.din[1] = 1'b1; repeat (15) step();
    bus.din[1] = 1'b0; repeat (15) step();
    check("len_rise", act_len[1], HOLD);
    bus.mode = 2'b10;
    clr_len();
    bus.din[1] = 1'b1; repeat (15) step();
    bus.din[1] = 1'b0; repeat (15) step();
    check("len_fall", act_len[1], HOLD);

    // Retrigger: edges 4 cycles apart keep ch2 lit until HOLD after the last.
    bus.mode   = 2'b00;
    bus.retrig = 1'b1;
    clr_len();
    for (int k = 0; k < 3; k++) begin
      bus.din[2] = ~bus.din[2];
      repeat (4) step();
    end
    repeat (20) step();
    check("len_retrig", act_len[2], 8 + HOLD);
    bus.retrig = 1'b0;
    clr_len();
    for (int k = 0; k < 3; k++) begin
      bus.din[2] = ~bus.din[2];
      repeat (4) step();
    end
    repeat (20) step();
    check("len_noretrig", act_len[2], HOLD);

    // All channels at once, then reset mid-pulse.
    bus.din = ~bus.din;
    repeat (7) step();
    check("all_active", bus.active, 4'hF);
    do_reset(2);
    clr_len();
    repeat (20) step();
    check("no_resume", act_len[0] + act_len[1] + act_len[2] + act_len[3], 0);

    // dout waveform of one trigger on ch3.
    bus.din[3] = ~bus.din[3];
    for (int k = 0; k < 14; k++) begin
      step();
      pat[13-k] = bus.dout[3];
    end
`ifdef ACTIVITY_STRETCH_BLINK_EN
    pat_exp = 14'b00_1100110011_00;
`else
    pat_exp = 14'b00_1111111111_00;
`endif
    check("dout3_pattern", pat, pat_exp);

    // Random traffic with occasional mode/retrig changes and resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 29) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) bus.retrig = 1'($urandom_range(0, 1));
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 6) == 0) bus.din[i] = ~bus.din[i];
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
